// File: rtl/md5_match.sv
`default_nettype none
// ============================================================================
// Module   : md5_match
// Purpose  : MD5 search result stage. Tracks in-flight candidates, pairs them
//            with returned digests and latches the first one matching target.
//            Optional define MD5_MATCH_MASK_EN adds a per-bit compare mask.
// Revision : 1.0  initial release
// ============================================================================
module md5_match #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 48
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [0:127]     msg_in,
    input  logic             msg_in_valid,
    input  logic [0:127]     digest,
    input  logic             digest_valid,
    input  logic [0:127]     target,
    input  logic             target_load,
`ifdef MD5_MATCH_MASK_EN
    input  logic [0:127]     target_mask,
`endif
    output logic             found,
    output logic [0:127]     found_msg,
    output logic [CNT_W-1:0] hash_count,
    output logic             armed,
    output logic             err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] c_full_cnt = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FOUND = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [0:127]     mem_q [DEPTH];
    logic [0:127]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [0:127]     target_q, target_d;
    logic             found_q, found_d;
    logic [0:127]     found_msg_q, found_msg_d;
    logic [CNT_W-1:0] hash_count_q, hash_count_d;
    logic             err_q, err_d;

    logic             w_full, w_empty, w_push, w_pop, w_match, w_hit;
    logic [0:127]     w_head, w_target;

`ifdef MD5_MATCH_MASK_EN
    logic [0:127]     mask_q, mask_d;
    logic [0:127]     w_mask;
`endif

    always_comb begin
        w_full   = (count_q == c_full_cnt);
        w_empty  = (count_q == '0);
        w_pop    = digest_valid & ~w_empty;
        // A pop in the same cycle frees the slot a full FIFO would otherwise refuse
        w_push   = msg_in_valid & (~w_full | w_pop);
        w_head   = mem_q[rd_ptr_q];
        w_target = target_load ? target : target_q;
`ifdef MD5_MATCH_MASK_EN
        w_mask   = target_load ? target_mask : mask_q;
        w_match  = ((digest & w_mask) == (w_target & w_mask));
`else
        w_match  = (digest == w_target);
`endif
        // A coincident load arms the comparator for this very digest
        w_hit    = (target_load | (state_q == ST_ARMED)) & w_pop & w_match;
    end

    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        target_d     = target_q;
        state_d      = state_q;
        found_d      = found_q;
        found_msg_d  = found_msg_q;
        err_d        = err_q;
        hash_count_d = hash_count_q + {{(CNT_W-1){1'b0}}, digest_valid};
`ifdef MD5_MATCH_MASK_EN
        mask_d       = mask_q;
`endif

        if (w_push) begin
            mem_d[wr_ptr_q] = msg_in;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase

        if ((digest_valid & w_empty) | (msg_in_valid & w_full & ~w_pop)) begin
            err_d = 1'b1;
        end

        if (target_load) begin
            target_d    = target;
`ifdef MD5_MATCH_MASK_EN
            mask_d      = target_mask;
`endif
            state_d     = ST_ARMED;
            found_d     = 1'b0;
            found_msg_d = '0;
        end
        if (w_hit) begin
            state_d     = ST_FOUND;
            found_d     = 1'b1;
            found_msg_d = w_head;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            target_q     <= '0;
            state_q      <= ST_IDLE;
            found_q      <= 1'b0;
            found_msg_q  <= '0;
            hash_count_q <= '0;
            err_q        <= 1'b0;
`ifdef MD5_MATCH_MASK_EN
            mask_q       <= '0;
`endif
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            target_q     <= target_d;
            state_q      <= state_d;
            found_q      <= found_d;
            found_msg_q  <= found_msg_d;
            hash_count_q <= hash_count_d;
            err_q        <= err_d;
`ifdef MD5_MATCH_MASK_EN
            mask_q       <= mask_d;
`endif
        end
    end

    assign found      = found_q;
    assign found_msg  = found_msg_q;
    assign hash_count = hash_count_q;
    assign armed      = (state_q == ST_ARMED);
    assign err        = err_q;

endmodule
`default_nettype wire

// File: doc/md5_match.md
# md5_match

Downstream result stage for the MD5 search datapath. It observes each candidate message as it is issued to the MD5 core and holds it in a small in-flight FIFO. It pairs each returned digest with the oldest outstanding message and compares the digest against a loaded target hash. On a hit it latches the matching candidate and raises `found` for the top-level LED. It also counts digests processed.

## Interface
Parameters:
- `DEPTH`, 4: in-flight message FIFO entries; power of two, 2..16.
- `CNT_W`, 48: width of `hash_count`.

Ports (all 128-bit vectors use `[0:127]` ordering, bit 0 = MSB of first message byte, matching the MD5 core):
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `msg_in`  in  128  candidate message, sampled when `msg_in_valid`=1.
- `msg_in_valid`  in  1  one-cycle strobe: message issued to MD5 core.
- `digest`  in  128  MD5 core output.
- `digest_valid`  in  1  one-cycle strobe: `digest` valid.
- `target`  in  128  target hash, sampled when `target_load`=1.
- `target_load`  in  1  load target and arm comparator.
- `found`  out  1  sticky: match detected.
- `found_msg`  out  128  message whose digest matched.
- `hash_count`  out  CNT_W  digests received since reset.
- `armed`  out  1  a target is loaded and no match yet.
- `err`  out  1  sticky: FIFO overflow or digest with no outstanding message.

## Operation
- States: IDLE (no target), ARMED, FOUND.
- IDLE -> ARMED on `target_load`.
- ARMED -> FOUND on a compare hit.
- Any state -> ARMED on `target_load`; this clears `found` and `found_msg`. The FIFO and `hash_count` are untouched.
- Push: `msg_in_valid`=1 writes `msg_in` at the tail.
- Pop: `digest_valid`=1 removes the head entry and compares it against `digest`.
- Compare occurs only in ARMED. In IDLE and FOUND, digests still pop and count but never change `found`/`found_msg`.
- Hit (ARMED, FIFO non-empty, digest equals target):
  - `found`<=1, `found_msg`<=head entry, state FOUND.
  - Only the first hit after arming is kept.
- Push and pop in the same cycle: both occur.
  - When full, the pop frees a slot, the push succeeds, and occupancy is unchanged.
  - When empty, the pop is an underflow: `err`<=1 and no compare. The push still succeeds.
- Push when full without a pop: message dropped, `err`<=1.
- Pop when empty: `err`<=1, no compare, `hash_count` still increments.
- `target_load` coinciding with a digest: the compare uses the new target, and the resulting state is ARMED or FOUND per that compare.
- `hash_count` increments by 1 on every `digest_valid` and wraps modulo 2^CNT_W without any flag.
- `err` clears only on reset.

## Timing
- Reset values: `found`=0, `found_msg`=0, `hash_count`=0, `armed`=0, `err`=0, target=0, FIFO empty, state IDLE.
- `found`, `found_msg`, `armed`, `err` and `hash_count` are registered and update on the edge that samples the triggering strobe; they are visible the following cycle.
- Digest-to-`found` latency: 1 cycle.
- The FIFO is storage only; it adds no latency to the compare path.
- The comparator is a single-cycle 128-bit equality against the registered target.
- `armed` equals (state == ARMED).
- Reset asserted mid-operation discards all FIFO contents and returns everything to the reset values immediately.

## Configuration
- `MD5_MATCH_MASK_EN` defined:
  - Adds input port `target_mask` (128 bits, `[0:127]`), sampled with `target`.
  - A hit requires `(digest & mask) == (target & mask)`. This supports partial-prefix searches.
  - An all-zero mask therefore matches the first digest after arming.
- Not defined: no `target_mask` port, and full 128-bit equality is required.

## Test plan
- Reset, load target `82cf9fa647dd1b3fbd9de71bbfb83fb2`. Issue messages M0, M1, M2; return digests D0 (miss), D1 (=target), D2 -> `found`=1 one cycle after D1, `found_msg`=M1, remains M1 after D2, `hash_count`=3, `err`=0.
- DEPTH=4: issue 5 messages with no digests -> `err`=1 on the fifth. Four subsequent digests pop M0..M3 in order.
- `digest_valid` with the FIFO empty -> `err`=1, `hash_count`=1, `found`=0.
- FIFO full (4 entries), simultaneous `msg_in_valid` and `digest_valid` -> no error, occupancy stays 4, head advances.
- Digests with no target loaded (IDLE) -> counted, `found`=0, `armed`=0. In FOUND, `target_load` -> `found`=0, `armed`=1, and a later match re-latches the new message.
- With `MD5_MATCH_MASK_EN`, mask = upper 16 bits set, target `82cf0000...` -> digest `82cf9fa6...` hits; digest `82ce...` misses.
